tetris_display_compositor: RTL and testbench
============================================

# tetris_display_compositor

- Registered, parametrised display compositor for the Tetris playfield.
- Sits between the game FSM and the LED/VGA frame driver.
- Merges the stored board, the falling block and the post-clear board according to the game state.
- Adds two frame-timed animations: a blinking line-clear flash, and an optional game-over fill sweep.

## Interface

Parameters:
- ROWS, 20, playfield rows; row 0 is the top.
- COLS, 10, playfield columns.
- FLASH_TOGGLES, 6, number of frame ticks spent in the line-clear flash (even, ≥2).

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- frame_tick  in  1  one-cycle pulse per display frame.
- game_state  in  3  game FSM state: INIT=0, SPAWN=1, FALLING=2, ROTATE=3, STUCK=4, LANDED=5, EVAL=6, GAMEOVER=7.
- stored_array  in  ROWS×COLS  locked cells.
- falling_block_display  in  ROWS×COLS  active piece cells.
- cleared_array  in  ROWS×COLS  board after row removal.
- full_rows  in  ROWS  rows being cleared; valid while game_state==EVAL.
- display_array  out  ROWS×COLS  registered composited frame.
- flash_active  out  1  high while in FLASH.
- flash_done  out  1  one-cycle pulse when the flash completes.
- sweep_done  out  1  one-cycle pulse when the game-over sweep completes.

## Operation

Compositor FSM states: LIVE, FLASH, CLEARED, SWEEP, SWEPT.

LIVE — display_q is loaded every cycle from the state mux:
- INIT, LANDED, GAMEOVER → stored_array.
- SPAWN, FALLING, ROTATE, STUCK → stored_array | falling_block_display.
- EVAL → cleared_array.

Transitions out of LIVE:
- game_state==EVAL with full_rows≠0 → FLASH. Latch full_rows into row_mask; clear tick_cnt and phase.
- game_state==EVAL with full_rows==0 → stay in LIVE, showing cleared_array. No flash and no flash_done.
- game_state==GAMEOVER → SWEEP with the macro defined (row_idx=ROWS-1); stays in LIVE without it.

FLASH:
- Display: stored_array with row_mask rows forced to 0 when phase=1, shown unmodified when phase=0. The first displayed phase is 0.
- Each frame_tick: phase toggles and tick_cnt increments.
- When tick_cnt reaches FLASH_TOGGLES: go to CLEARED and pulse flash_done on the same cycle.
- row_mask is held; later changes to full_rows are ignored.

CLEARED:
- Display cleared_array.
- Return to LIVE when game_state≠EVAL.

SWEEP:
- Display stored_array with rows row_idx..ROWS-1 forced to all ones.
- On each frame_tick, decrement row_idx.
- On the tick at which row_idx==0: go to SWEPT and pulse sweep_done.

SWEPT:
- Display all ones.

Global rules:
- game_state==INIT forces LIVE from any state (abort) in the same cycle. row_mask, tick_cnt, phase and row_idx are cleared.
- A game_state value outside the defined set behaves as INIT.
- Widths: tick_cnt is $clog2(FLASH_TOGGLES+1) bits; row_idx is $clog2(ROWS) bits. Neither counter wraps; each saturates at its terminal value.

## Timing

- Reset values: display_array=0, flash_active=0, flash_done=0, sweep_done=0. FSM=LIVE, all counters 0.
- Latency: display_array reflects its inputs 1 cycle later (a single register stage). flash_active is registered and aligned with display_array.
- A frame_tick coinciding with entry into FLASH or SWEEP is ignored; counting starts on the next tick.
- Flash duration: exactly FLASH_TOGGLES frame_ticks after entry. flash_done is asserted for exactly one cycle.
- Sweep duration: exactly ROWS frame_ticks. The first tick fills row ROWS-1; the last tick fills row 0.
- rst asserted mid-animation: all outputs return to reset values on the next edge, and pulses are suppressed.
- INIT arriving on the same cycle as a terminal tick: the abort wins, and no done pulse is emitted.

## Configuration

- Macro: TETRIS_DISPLAY_SWEEP_EN.
- Defined: SWEEP and SWEPT are compiled in. GAMEOVER triggers the bottom-up fill animation, and sweep_done is driven as described above.
- Undefined: SWEEP and SWEPT logic and row_idx are removed. GAMEOVER shows stored_array from LIVE, and sweep_done is tied to 0.

## Test plan

- Reset: hold rst 2 cycles with random inputs → display_array=0, flash_active=0, flash_done=0, sweep_done=0.
- Live mux: game_state=FALLING, stored row19=0x3FF, falling row0=0x030 → one cycle later display row19=0x3FF, row0=0x030. Switch to LANDED → row0=0.
- Flash: EVAL, full_rows=bit19, stored row19=0x3FF, FLASH_TOGGLES=6, one frame_tick every 4 cycles. Required response:
  - row19 alternates 0x3FF/0x000 on successive ticks.
  - flash_done pulses once on the 6th tick.
  - display then equals cleared_array.
- No-clear EVAL: full_rows=0 → flash_active stays 0, display=cleared_array one cycle later, flash_done never pulses.
- Sweep (macro defined): GAMEOVER, ROWS=20, with 20 frame_ticks. Required response:
  - After tick k, rows 20-k..19 are 0x3FF.
  - sweep_done pulses on tick 20.
  - display is all ones afterwards.
  - Macro undefined → display stays stored_array and sweep_done stays 0.
- Abort: during FLASH after tick 3, drive INIT → next cycle flash_active=0 and display=stored_array. A subsequent EVAL restarts the flash from tick 0.

Source files
------------

// File: rtl/tetris_display_compositor.sv
// Registered Tetris playfield compositor: state-based board merge, line-clear flash
// and optional game-over fill sweep (enabled by TETRIS_DISPLAY_SWEEP_EN).
module tetris_display_compositor #(
   parameter int unsigned ROWS          = 20,
   parameter int unsigned COLS          = 10,
   parameter int unsigned FLASH_TOGGLES = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 frame_tick,
   input  logic [2:0]           game_state,
   input  logic [ROWS*COLS-1:0] stored_array,
   input  logic [ROWS*COLS-1:0] falling_block_display,
   input  logic [ROWS*COLS-1:0] cleared_array,
   input  logic [ROWS-1:0]      full_rows,
   output logic [ROWS*COLS-1:0] display_array,
   output logic                 flash_active,
   output logic                 flash_done,
   output logic                 sweep_done
);

   localparam int unsigned CW = $clog2(FLASH_TOGGLES + 1);
   localparam logic [CW-1:0] TICK_END = CW'(FLASH_TOGGLES);

   typedef enum logic [2:0] {
      GS_INIT     = 3'd0,
      GS_SPAWN    = 3'd1,
      GS_FALLING  = 3'd2,
      GS_ROTATE   = 3'd3,
      GS_STUCK    = 3'd4,
      GS_LANDED   = 3'd5,
      GS_EVAL     = 3'd6,
      GS_GAMEOVER = 3'd7
   } game_state_e;

   typedef enum logic [2:0] {
      LIVE    = 3'd0,
      FLASH   = 3'd1,
      CLEARED = 3'd2,
      SWEEP   = 3'd3,
      SWEPT   = 3'd4
   } comp_state_e;

   game_state_e gs;
   assign gs = game_state_e'(game_state);

   comp_state_e           state_q, state_n;
   logic [ROWS-1:0]       row_mask_q, row_mask_n;
   logic [CW-1:0]         tick_cnt_q, tick_cnt_n;
   logic                  phase_q, phase_n;
   logic [ROWS*COLS-1:0]  display_q, display_n;
   logic [ROWS*COLS-1:0]  flash_mask;
   logic                  flash_active_q, flash_done_q;
   logic                  is_init;

   always_comb begin
      is_init = 1'b0;
      case (gs)
         GS_SPAWN, GS_FALLING, GS_ROTATE, GS_STUCK,
         GS_LANDED, GS_EVAL, GS_GAMEOVER: is_init = 1'b0;
         default:                         is_init = 1'b1;
      endcase
   end

`ifdef TETRIS_DISPLAY_SWEEP_EN
   localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

   logic [RW-1:0]         row_idx_q, row_idx_n;
   logic [ROWS*COLS-1:0]  sweep_fill;
   logic                  sweep_done_q;

   // Display is built from next-state values, so a row is shown filled once
   // row_idx has moved past it; the entry frame therefore shows no fill yet.
   always_comb begin
      sweep_fill = '0;
      for (int unsigned r = 0; r < ROWS; r++)
         sweep_fill[r*COLS +: COLS] = (r > 32'(row_idx_n)) ? '1 : '0;
   end
`endif

   always_comb begin
      flash_mask = '0;
      for (int unsigned r = 0; r < ROWS; r++)
         flash_mask[r*COLS +: COLS] = {COLS{row_mask_n[r]}};
   end

   always_comb begin
      state_n    = state_q;
      row_mask_n = row_mask_q;
      tick_cnt_n = tick_cnt_q;
      phase_n    = phase_q;
`ifdef TETRIS_DISPLAY_SWEEP_EN
      row_idx_n  = row_idx_q;
`endif
      if (is_init) begin
         state_n    = LIVE;
         row_mask_n = '0;
         tick_cnt_n = '0;
         phase_n    = 1'b0;
`ifdef TETRIS_DISPLAY_SWEEP_EN
         row_idx_n  = '0;
`endif
      end else begin
         case (state_q)
            LIVE: begin
               if (gs == GS_EVAL && full_rows != '0) begin
                  state_n    = FLASH;
                  row_mask_n = full_rows;
                  tick_cnt_n = '0;
                  phase_n    = 1'b0;
               end
`ifdef TETRIS_DISPLAY_SWEEP_EN
               else if (gs == GS_GAMEOVER) begin
                  state_n   = SWEEP;
                  row_idx_n = ROW_LAST;
               end
`endif
            end
            FLASH: begin
               if (frame_tick) begin
                  phase_n = ~phase_q;
                  if (tick_cnt_q != TICK_END)
                     tick_cnt_n = tick_cnt_q + 1'b1;
                  if (tick_cnt_n == TICK_END)
                     state_n = CLEARED;
               end
            end
            CLEARED: begin
               if (gs != GS_EVAL)
                  state_n = LIVE;
            end
`ifdef TETRIS_DISPLAY_SWEEP_EN
            SWEEP: begin
               if (frame_tick) begin
                  if (row_idx_q == '0)
                     state_n = SWEPT;
                  else
                     row_idx_n = row_idx_q - 1'b1;
               end
            end
            SWEPT: state_n = SWEPT;
`endif
            default: state_n = LIVE;
         endcase
      end
   end

   always_comb begin
      display_n = stored_array;
      case (state_n)
         LIVE: begin
            case (gs)
               GS_SPAWN, GS_FALLING, GS_ROTATE, GS_STUCK:
                  display_n = stored_array | falling_block_display;
               GS_EVAL:
                  display_n = cleared_array;
               default:
                  display_n = stored_array;
            endcase
         end
         FLASH:   display_n = phase_n ? (stored_array & ~flash_mask) : stored_array;
         CLEARED: display_n = cleared_array;
`ifdef TETRIS_DISPLAY_SWEEP_EN
         SWEEP:   display_n = stored_array | sweep_fill;
         SWEPT:   display_n = '1;
`endif
         default: display_n = stored_array;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= LIVE;
         row_mask_q     <= '0;
         tick_cnt_q     <= '0;
         phase_q        <= 1'b0;
         display_q      <= '0;
         flash_active_q <= 1'b0;
         flash_done_q   <= 1'b0;
      end else begin
         state_q        <= state_n;
         row_mask_q     <= row_mask_n;
         tick_cnt_q     <= tick_cnt_n;
         phase_q        <= phase_n;
         display_q      <= display_n;
         flash_active_q <= (state_n == FLASH);
         flash_done_q   <= (state_q == FLASH) && (state_n == CLEARED);
      end
   end

`ifdef TETRIS_DISPLAY_SWEEP_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         row_idx_q    <= '0;
         sweep_done_q <= 1'b0;
      end else begin
         row_idx_q    <= row_idx_n;
         sweep_done_q <= (state_q == SWEEP) && (state_n == SWEPT);
      end
   end
   assign sweep_done = sweep_done_q;
`else
   assign sweep_done = 1'b0;
`endif

   assign display_array = display_q;
   assign flash_active  = flash_active_q;
   assign flash_done    = flash_done_q;

endmodule

// File: tb/tb_tetris_display_compositor.sv
// Directed bench for tetris_display_compositor: reset, live mux, flash, no-clear EVAL,
// game-over sweep (or its absence) and abort/reset during animations.
module tb_tetris_display_compositor;

   localparam int ROWS = 20;
   localparam int COLS = 10;
   localparam int FT   = 6;
   localparam int W    = ROWS * COLS;

   localparam logic [2:0] S_INIT = 3'd0, S_FALLING = 3'd2, S_LANDED = 3'd5,
                          S_EVAL = 3'd6, S_GAMEOVER = 3'd7;

   logic            clk = 1'b0;
   logic            rst;
   logic            frame_tick;
   logic [2:0]      game_state;
   logic [W-1:0]    stored_array, falling_block_display, cleared_array;
   logic [ROWS-1:0] full_rows;
   logic [W-1:0]    display_array;
   logic            flash_active, flash_done, sweep_done;

   int checks = 0;
   int errors = 0;

   tetris_display_compositor #(
      .ROWS(ROWS), .COLS(COLS), .FLASH_TOGGLES(FT)
   ) dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick), .game_state(game_state),
      .stored_array(stored_array), .falling_block_display(falling_block_display),
      .cleared_array(cleared_array), .full_rows(full_rows),
      .display_array(display_array), .flash_active(flash_active),
      .flash_done(flash_done), .sweep_done(sweep_done)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
   endtask

   function automatic logic [W-1:0] put_row(input logic [W-1:0] v, input int r,
                                            input logic [COLS-1:0] val);
      logic [W-1:0] t;
      t = v;
      t[r*COLS +: COLS] = val;
      return t;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      for (int c = 0; c < 2; c++) begin
         for (int r = 0; r < ROWS; r++) begin
            stored_array[r*COLS +: COLS]          = COLS'($urandom_range(0, 1023));
            falling_block_display[r*COLS +: COLS] = COLS'($urandom_range(0, 1023));
            cleared_array[r*COLS +: COLS]         = COLS'($urandom_range(0, 1023));
         end
         full_rows  = ROWS'($urandom);
         game_state = 3'($urandom_range(0, 7));
         frame_tick = 1'($urandom_range(0, 1));
         step();
      end
      checks++; if (display_array !== '0) begin errors++; $display("FAIL reset_display got %h exp 0", display_array); end
      checks++; if (flash_active !== 1'b0) begin errors++; $display("FAIL reset_flash_active got %b exp 0", flash_active); end
      checks++; if (flash_done !== 1'b0) begin errors++; $display("FAIL reset_flash_done got %b exp 0", flash_done); end
      checks++; if (sweep_done !== 1'b0) begin errors++; $display("FAIL reset_sweep_done got %b exp 0", sweep_done); end
      frame_tick = 1'b0;
      game_state = S_INIT;
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic test_live_mux();
      logic [W-1:0] exp;
      stored_array          = put_row('0, 19, 10'h3FF);
      falling_block_display = put_row('0, 0, 10'h030);
      cleared_array         = put_row('0, 19, 10'h155);
      full_rows             = '0;
      game_state            = S_FALLING;
      step();
      exp = put_row(put_row('0, 19, 10'h3FF), 0, 10'h030);
      checks++; if (display_array !== exp) begin errors++; $display("FAIL live_falling got %h exp %h", display_array, exp); end
      checks++; if (flash_active !== 1'b0) begin errors++; $display("FAIL live_flash_active got %b exp 0", flash_active); end
      game_state = S_LANDED;
      step();
      checks++; if (display_array[0 +: COLS] !== 10'h000) begin errors++; $display("FAIL live_landed_row0 got %h exp 000", display_array[0 +: COLS]); end
      checks++; if (display_array[190 +: COLS] !== 10'h3FF) begin errors++; $display("FAIL live_landed_row19 got %h exp 3ff", display_array[190 +: COLS]); end
   endtask

   task automatic test_flash();
      logic [W-1:0] exp;
      int pulses;
      pulses = 0;
      stored_array  = put_row(put_row('0, 19, 10'h3FF), 5, 10'h155);
      cleared_array = put_row(put_row('0, 0, 10'h2AA), 6, 10'h155);
      full_rows     = ROWS'(1) << 19;
      game_state    = S_EVAL;
      frame_tick    = 1'b1;                 // coincides with entry: must be ignored
      step();
      frame_tick    = 1'b0;
      full_rows     = ROWS'(1) << 5;        // late change must not affect the held mask
      checks++; if (flash_active !== 1'b1) begin errors++; $display("FAIL flash_entry_active got %b exp 1", flash_active); end
      checks++; if (display_array !== stored_array) begin errors++; $display("FAIL flash_entry_display got %h exp %h", display_array, stored_array); end
      for (int k = 1; k <= FT; k++) begin
         tick();
         if (flash_done) pulses++;
         if (k < FT) begin
            exp = (k % 2 == 1) ? put_row(stored_array, 19, 10'h000) : stored_array;
            checks++; if (display_array !== exp) begin errors++; $display("FAIL flash_tick%0d_display got %h exp %h", k, display_array, exp); end
            checks++; if (flash_done !== 1'b0) begin errors++; $display("FAIL flash_tick%0d_done got %b exp 0", k, flash_done); end
            checks++; if (flash_active !== 1'b1) begin errors++; $display("FAIL flash_tick%0d_active got %b exp 1", k, flash_active); end
         end else begin
            checks++; if (flash_done !== 1'b1) begin errors++; $display("FAIL flash_final_done got %b exp 1", flash_done); end
            checks++; if (display_array !== cleared_array) begin errors++; $display("FAIL flash_final_display got %h exp %h", display_array, cleared_array); end
            checks++; if (flash_active !== 1'b0) begin errors++; $display("FAIL flash_final_active got %b exp 0", flash_active); end
         end
         for (int i = 0; i < 3; i++) begin
            step();
            if (flash_done) pulses++;
         end
      end
      checks++; if (pulses !== 1) begin errors++; $display("FAIL flash_done_count got %0d exp 1", pulses); end
      checks++; if (display_array !== cleared_array) begin errors++; $display("FAIL flash_cleared_hold got %h exp %h", display_array, cleared_array); end
      game_state = S_FALLING;
      step();
      exp = stored_array | falling_block_display;
      checks++; if (display_array !== exp) begin errors++; $display("FAIL flash_return_live got %h exp %h", display_array, exp); end
   endtask

   task automatic test_no_clear();
      int pulses;
      pulses = 0;
      full_rows  = '0;
      game_state = S_EVAL;
      step();
      checks++; if (display_array !== cleared_array) begin errors++; $display("FAIL noclr_display got %h exp %h", display_array, cleared_array); end
      for (int k = 0; k < 8; k++) begin
         if (k % 2 == 0) tick(); else step();
         if (flash_done) pulses++;
         checks++; if (flash_active !== 1'b0) begin errors++; $display("FAIL noclr_active%0d got %b exp 0", k, flash_active); end
      end
      checks++; if (pulses !== 0) begin errors++; $display("FAIL noclr_done_count got %0d exp 0", pulses); end
      game_state = S_LANDED;
      step();
   endtask

   task automatic test_sweep();
      logic [W-1:0] exp;
      game_state = S_GAMEOVER;
      step();
      checks++; if (display_array !== stored_array) begin errors++; $display("FAIL sweep_entry_display got %h exp %h", display_array, stored_array); end
`ifdef TETRIS_DISPLAY_SWEEP_EN
      for (int k = 1; k <= ROWS; k++) begin
         tick();
         exp = stored_array;
         for (int r = ROWS - k; r < ROWS; r++) exp = put_row(exp, r, '1);
         checks++; if (display_array !== exp) begin errors++; $display("FAIL sweep_tick%0d_display got %h exp %h", k, display_array, exp); end
         checks++; if (sweep_done !== (k == ROWS)) begin errors++; $display("FAIL sweep_tick%0d_done got %b exp %b", k, sweep_done, k == ROWS); end
         step();
      end
      exp = '1;
      checks++; if (display_array !== exp) begin errors++; $display("FAIL swept_display got %h exp all ones", display_array); end
      checks++; if (sweep_done !== 1'b0) begin errors++; $display("FAIL swept_done_after got %b exp 0", sweep_done); end
`else
      for (int k = 1; k <= 5; k++) begin
         tick();
         checks++; if (display_array !== stored_array) begin errors++; $display("FAIL nosweep_tick%0d_display got %h exp %h", k, display_array, stored_array); end
         checks++; if (sweep_done !== 1'b0) begin errors++; $display("FAIL nosweep_tick%0d_done got %b exp 0", k, sweep_done); end
      end
`endif
      game_state = S_INIT;
      step();
      checks++; if (display_array !== stored_array) begin errors++; $display("FAIL sweep_abort_display got %h exp %h", display_array, stored_array); end
   endtask

   task automatic test_abort();
      logic [W-1:0] exp;
      int pulses;
      full_rows  = ROWS'(1) << 19;
      game_state = S_EVAL;
      step();
      for (int k = 0; k < 3; k++) begin tick(); step(); end
      game_state = S_INIT;
      step();
      checks++; if (flash_active !== 1'b0) begin errors++; $display("FAIL abort_active got %b exp 0", flash_active); end
      checks++; if (display_array !== stored_array) begin errors++; $display("FAIL abort_display got %h exp %h", display_array, stored_array); end
      game_state = S_EVAL;
      step();
      checks++; if (flash_active !== 1'b1) begin errors++; $display("FAIL restart_active got %b exp 1", flash_active); end
      pulses = 0;
      for (int k = 1; k <= FT; k++) begin
         tick();
         if (k == 1) begin
            exp = put_row(stored_array, 19, 10'h000);
            checks++; if (display_array !== exp) begin errors++; $display("FAIL restart_tick1_display got %h exp %h", display_array, exp); end
         end
         if (flash_done) begin
            pulses++;
            checks++; if (k !== FT) begin errors++; $display("FAIL restart_done_tick got %0d exp %0d", k, FT); end
         end
      end
      checks++; if (pulses !== 1) begin errors++; $display("FAIL restart_done_count got %0d exp 1", pulses); end
      // terminal tick coinciding with INIT: abort wins
      game_state = S_LANDED;
      step();
      game_state = S_EVAL;
      step();
      for (int k = 1; k < FT; k++) tick();
      game_state = S_INIT;
      tick();
      checks++; if (flash_done !== 1'b0) begin errors++; $display("FAIL abort_terminal_done got %b exp 0", flash_done); end
      checks++; if (display_array !== stored_array) begin errors++; $display("FAIL abort_terminal_display got %h exp %h", display_array, stored_array); end
      step();
      checks++; if (flash_done !== 1'b0) begin errors++; $display("FAIL abort_terminal_late got %b exp 0", flash_done); end
   endtask

   task automatic test_reset_mid();
      game_state = S_EVAL;
      step();
      tick();
      rst = 1'b1;
      tick();
      checks++; if (display_array !== '0) begin errors++; $display("FAIL rstmid_display got %h exp 0", display_array); end
      checks++; if (flash_active !== 1'b0) begin errors++; $display("FAIL rstmid_active got %b exp 0", flash_active); end
      checks++; if (flash_done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b exp 0", flash_done); end
      rst = 1'b0;
      game_state = S_LANDED;
      step();
      checks++; if (display_array !== stored_array) begin errors++; $display("FAIL rstmid_live got %h exp %h", display_array, stored_array); end
   endtask

   initial begin
      frame_tick = 1'b0;
      test_reset();
      test_live_mux();
      test_flash();
      test_no_clear();
      test_sweep();
      test_abort();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running exp finished");
      $fatal(1);
   end

endmodule
